// File: rtl/result_streamer.sv
// rtl/result_streamer.sv - streams NUM_RESULTS words from output_ram through a 2-entry FIFO onto a valid/ready port
module result_streamer #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int NUM_RESULTS = 196,
  parameter int BASE_ADDR   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy
);
  localparam int CW = $clog2(NUM_RESULTS + 1);
  localparam logic [CW-1:0]     CNT_END   = CW'(NUM_RESULTS);
  localparam logic [CW-1:0]     CNT_LAST  = CW'(NUM_RESULTS - 1);
  localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]     send_cnt_q, send_cnt_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              inflight_q, inflight_d;
  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic [2:0]        occupancy;
  logic              start_acc, push, pop, slot_free;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      issue_cnt_q <= '0;
      send_cnt_q  <= '0;
      rd_addr_q   <= ADDR_BASE;
      inflight_q  <= 1'b0;
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      send_cnt_q  <= send_cnt_d;
      rd_addr_q   <= rd_addr_d;
      inflight_q  <= inflight_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  assign m_valid   = (count_q != 2'd0);
  assign m_data    = mem_q[rd_ptr_q];
  assign m_last    = m_valid && (send_cnt_q == CNT_LAST);
  assign rd_addr   = rd_addr_q;
  assign pop       = m_valid && m_ready;
  assign push      = inflight_q;
  assign start_acc = start && (state_q == S_IDLE);

  // A word leaving this cycle frees its slot, which is what sustains one beat per cycle.
  assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign slot_free = (occupancy < 3'd2);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (rd_en && (issue_cnt_q == CNT_LAST)) state_d = S_DRAIN;
      S_DRAIN: if (pop && m_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_en = (state_q == S_RUN) && slot_free && (issue_cnt_q != CNT_END);
    busy  = (state_q != S_IDLE);
  end

  always_comb begin
    issue_cnt_d = issue_cnt_q;
    send_cnt_d  = send_cnt_q;
    rd_addr_d   = rd_addr_q;
    inflight_d  = rd_en;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (start_acc) begin
      issue_cnt_d = '0;
      send_cnt_d  = '0;
      rd_addr_d   = ADDR_BASE;
    end
    // The address stops on the final read so it never presents one past the frame.
    if (rd_en) begin
      issue_cnt_d = issue_cnt_q + CW'(1);
      if (issue_cnt_q != CNT_LAST) rd_addr_d = rd_addr_q + ADDR_W'(1);
    end
    if (push) begin
      mem_d[wr_ptr_q] = rd_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d   = ~rd_ptr_q;
      send_cnt_d = send_cnt_q + CW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end
endmodule

// File: tb/tb_result_streamer.sv
// tb/tb_result_streamer.sv - randomized self-checking bench for result_streamer
module tb_result_streamer;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int N = 196;
  localparam int BASE = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, m_ready, start1, m_ready1;
  logic rd_en, rd_en1, m_valid, m_valid1, m_last, m_last1, busy, busy1;
  logic [AW-1:0] rd_addr, rd_addr1;
  logic [DW-1:0] rd_data, rd_data1, m_data, m_data1;
  logic [DW-1:0] ram [256];

  int checks = 0;
  int errors = 0;

  result_streamer u_dut (
    .clk(clk), .reset(reset), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .busy(busy)
  );

  result_streamer #(.DATA_W(DW), .ADDR_W(AW), .NUM_RESULTS(1), .BASE_ADDR(255)) u_one (
    .clk(clk), .reset(reset), .start(start1), .rd_en(rd_en1), .rd_addr(rd_addr1),
    .rd_data(rd_data1), .m_data(m_data1), .m_valid(m_valid1), .m_ready(m_ready1),
    .m_last(m_last1), .busy(busy1)
  );

  always @(posedge clk) begin
    if (rd_en) rd_data <= ram[rd_addr];
    if (rd_en1) rd_data1 <= ram[rd_addr1];
  end

  // Reference model of the main instance: frame progress in beats and reads.
  bit mdl_busy = 0;
  int beat = 0, issued = 0, sent = 0, since = 0;
  int beats_total = 0, lasts_total = 0, gaps = 0;
  bit prev_stall = 0, prev_last = 0, mon_pop = 0, busy_before = 0;
  logic [DW-1:0] prev_data;

  always @(negedge clk) begin
    #2;
    mon_pop = (m_valid === 1'b1) && (m_ready === 1'b1);
    if (reset === 1'b1) begin
      checks++;
      if (busy !== mdl_busy) begin
        errors++; $display("FAIL busy: got %0b expected %0b (beat %0d)", busy, mdl_busy, beat);
      end
      if (!mdl_busy) begin
        checks++;
        if (m_valid !== 1'b0 || rd_en !== 1'b0) begin
          errors++; $display("FAIL idle_quiet: m_valid %0b rd_en %0b expected 0 0", m_valid, rd_en);
        end
      end else begin
        if (sent == 0) begin
          checks++;
          if (m_valid !== (since >= 2)) begin
            errors++; $display("FAIL first_valid: got %0b expected %0b at %0d edges after start", m_valid, since >= 2, since);
          end
        end
        if (since >= 2 && m_valid !== 1'b1) gaps++;
        checks++;
        if (m_last !== (m_valid && beat == N - 1)) begin
          errors++; $display("FAIL m_last: got %0b expected %0b at beat %0d", m_last, m_valid && beat == N - 1, beat);
        end
      end
      if (prev_stall) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last) begin
          errors++; $display("FAIL stall_hold: valid %0b data %0d last %0b expected 1 %0d %0b", m_valid, m_data, m_last, prev_data, prev_last);
        end
      end
      if (rd_en === 1'b1) begin
        checks++;
        if (!mdl_busy || issued >= N || rd_addr !== AW'(BASE + issued) || (issued - sent - int'(mon_pop)) >= 2) begin
          errors++; $display("FAIL rd_issue: addr %0d expected %0d issued %0d held %0d", rd_addr, AW'(BASE + issued), issued, issued - sent);
        end
      end
      if (mon_pop) begin
        checks++;
        if (m_data !== ram[(BASE + beat) % 256] || m_last !== (beat == N - 1)) begin
          errors++; $display("FAIL beat_data: beat %0d got %0d last %0b expected %0d last %0b", beat, m_data, m_last, ram[(BASE + beat) % 256], beat == N - 1);
        end
      end
    end
    if (reset !== 1'b1) begin
      mdl_busy = 0; beat = 0; issued = 0; sent = 0; prev_stall = 0;
    end else begin
      busy_before = mdl_busy;
      prev_stall = (m_valid === 1'b1) && (m_ready !== 1'b1);
      prev_data = m_data;
      prev_last = m_last;
      if (rd_en === 1'b1) issued++;
      if (mon_pop) begin
        beats_total++;
        if (m_last === 1'b1) lasts_total++;
        beat++; sent++;
        if (beat == N) mdl_busy = 0;
      end
      since++;
      if (start === 1'b1 && !busy_before) begin
        mdl_busy = 1; beat = 0; issued = 0; sent = 0; since = 0;
      end
    end
  end

  // Called at a negedge; leaves start low at the following negedge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_until_idle(input int pct, output bit timed_out);
    timed_out = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (!mdl_busy) begin
        timed_out = 1'b0;
        break;
      end
      m_ready = ($urandom_range(99) < pct);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #3;
      checks++;
      if (rd_en !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b0 || m_last !== 1'b0 || m_data !== '0 || rd_addr !== AW'(BASE)) begin
        errors++; $display("FAIL reset_state: rd_en %0b m_valid %0b busy %0b m_last %0b m_data %0d rd_addr %0d expected all 0", rd_en, m_valid, busy, m_last, m_data, rd_addr);
      end
    end
    @(negedge clk);
    reset = 1'b1; start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_frame();
    int b0, l0, g0;
    bit to;
    b0 = beats_total; l0 = lasts_total; g0 = gaps;
    m_ready = 1'b1;
    pulse_start();
    run_until_idle(100, to);
    checks++;
    if (to || beats_total - b0 != N || lasts_total - l0 != 1 || gaps - g0 != 0) begin
      errors++; $display("FAIL full_frame: timeout %0b beats %0d lasts %0d gaps %0d expected 0 %0d 1 0", to, beats_total - b0, lasts_total - l0, gaps - g0, N);
    end
  endtask

  task automatic test_backpressure();
    int b0, l0;
    bit to;
    b0 = beats_total; l0 = lasts_total;
    m_ready = 1'b0;
    pulse_start();
    run_until_idle(30, to);
    checks++;
    if (to || beats_total - b0 != N || lasts_total - l0 != 1) begin
      errors++; $display("FAIL backpressure: timeout %0b beats %0d lasts %0d expected 0 %0d 1", to, beats_total - b0, lasts_total - l0, N);
    end
  endtask

  task automatic test_start_while_busy();
    int b0, l0, c;
    bit to;
    b0 = beats_total; l0 = lasts_total;
    pulse_start();
    for (c = 0; c < 2000 && beat < 50; c++) begin
      m_ready = ($urandom_range(99) < 70);
      @(negedge clk);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_until_idle(70, to);
    checks++;
    if (to || c >= 2000 || beats_total - b0 != N || lasts_total - l0 != 1) begin
      errors++; $display("FAIL start_while_busy: timeout %0b beats %0d lasts %0d expected 0 %0d 1", to, beats_total - b0, lasts_total - l0, N);
    end
  endtask

  task automatic test_back_to_back();
    int b0;
    bit to;
    m_ready = 1'b1;
    pulse_start();
    run_until_idle(100, to);
    b0 = beats_total;
    pulse_start();
    #3;
    checks++;
    if (to || busy !== 1'b1) begin
      errors++; $display("FAIL back_to_back_start: timeout %0b busy %0b expected 0 1", to, busy);
    end
    run_until_idle(100, to);
    checks++;
    if (to || beats_total - b0 != N) begin
      errors++; $display("FAIL back_to_back_frame: timeout %0b beats %0d expected 0 %0d", to, beats_total - b0, N);
    end
  endtask

  task automatic test_reset_mid_frame();
    int b0, l0, c;
    bit to;
    m_ready = 1'b1;
    pulse_start();
    for (c = 0; c < 2000 && beat < 100; c++) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #3;
    checks++;
    if (c >= 2000 || m_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid_frame: m_valid %0b busy %0b expected 0 0", m_valid, busy);
    end
    b0 = beats_total;
    repeat (5) @(negedge clk);
    checks++;
    if (beats_total != b0 || rd_en !== 1'b0) begin
      errors++; $display("FAIL reset_no_beats: beats %0d rd_en %0b expected 0 0", beats_total - b0, rd_en);
    end
    l0 = lasts_total;
    pulse_start();
    run_until_idle(50, to);
    checks++;
    if (to || beats_total - b0 != N || lasts_total - l0 != 1) begin
      errors++; $display("FAIL restart_frame: timeout %0b beats %0d lasts %0d expected 0 %0d 1", to, beats_total - b0, lasts_total - l0, N);
    end
  endtask

  task automatic test_single_result();
    int reads, beats, lasts_ok;
    reads = 0; beats = 0; lasts_ok = 0;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int c = 0; c < 30; c++) begin
      m_ready1 = ($urandom_range(99) < 50);
      #3;
      if (rd_en1 === 1'b1) begin
        reads++;
        checks++;
        if (rd_addr1 !== 8'd255) begin
          errors++; $display("FAIL single_addr: got %0d expected 255", rd_addr1);
        end
      end
      if (m_valid1 === 1'b1 && m_ready1 === 1'b1) begin
        beats++;
        checks++;
        if (m_data1 !== ram[255] || m_last1 !== 1'b1) begin
          errors++; $display("FAIL single_beat: data %0d last %0b expected %0d 1", m_data1, m_last1, ram[255]);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (reads != 1 || beats != 1 || busy1 !== 1'b0) begin
      errors++; $display("FAIL single_frame: reads %0d beats %0d busy %0b expected 1 1 0", reads, beats, busy1);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = i * 3 + 1;
    ram[255] = $urandom;
    ram[0] = ram[255] ^ 32'h5a5a_0001;
    ram[0][0] = 1'b1;
    ram[0] = 32'd1;
    rd_data = '0; rd_data1 = '0;
    reset = 1'b0; start = 1'b0; m_ready = 1'b0; start1 = 1'b0; m_ready1 = 1'b0;
    @(negedge clk);
    test_reset();
    test_full_frame();
    test_backpressure();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_frame();
    test_single_result();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
